// File: rtl/highest_common_factor.sv
`default_nettype none
// ============================================================================
//  Module      : highest_common_factor
//  Description : Iterative greatest-common-divisor engine for two unsigned
//                N-bit operands. Uses subtractive Euclid, one subtraction per
//                clock, behind a start/done handshake.
//  Ports       : clk   - rising-edge clock
//                rst   - synchronous active-high reset
//                start - request pulse, sampled only while idle
//                in1   - first operand, captured on the accepted start edge
//                in2   - second operand, captured on the accepted start edge
//                busy  - high while a computation is in progress
//                done  - one-cycle pulse when hcf takes a new result
//                hcf   - last computed result, held between computations
//  Revision    : 1.0 - initial release
// ============================================================================
module highest_common_factor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hcf
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_hcf;
    logic         r_done;
    logic         w_finish;
    logic [N-1:0] w_result;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and termination decode. The termination tests are
    // ordered so a zero operand wins over the equality test; this gives
    // hcf(0,0)=0 and hcf(0,x)=x without a special case.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        w_result     = r_a;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_a == '0) begin
                    w_finish = 1'b1;
                    w_result = r_b;
                end else if ((r_b == '0) || (r_a == r_b)) begin
                    w_finish = 1'b1;
                    w_result = r_a;
                end
                if (w_finish) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, subtract-the-smaller step, result latch.
    // Only the larger operand is reduced, so the subtraction never wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_hcf  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_a <= in1;
                    r_b <= in2;
                end
            end else if (w_finish) begin
                r_hcf <= w_result;
            end else if (r_a > r_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == S_CALC);
        done = r_done;
        hcf  = r_hcf;
    end

endmodule
`default_nettype wire

// File: tb/tb_highest_common_factor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_highest_common_factor
//  Description : Self-checking bench for highest_common_factor. The driver
//                pushes the expected result and completion cycle for every
//                accepted request; a negedge monitor pops and compares on
//                each done pulse and watches busy/hold behaviour every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_highest_common_factor;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         busy;
    logic         done;
    logic [N-1:0] hcf;

    typedef struct {
        int g;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   total;
    int   bad;
    int   exp_hold;
    logic prev_done;

    highest_common_factor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .hcf   (hcf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total = total + 1;
        if (got != want) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: modulo Euclid. The subtractive engine performs one
    // subtraction per unit of quotient, stopping one step early when the
    // operands become equal, so cycles = sum of quotients (1 for zeros).
    function automatic void ref_model(input int a, input int b, output int g, output int lat);
        int x, y, t, s;
        if (a == 0) begin
            g = b; lat = 1;
        end else if (b == 0) begin
            g = a; lat = 1;
        end else begin
            x = a; y = b; s = 0;
            while (y != 0) begin
                s = s + x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x; lat = s;
        end
    endfunction

    // Called at posedge+1. Presents a request, lets the next edge accept
    // it, then records the expectation.
    task automatic start_op(input int a, input int b);
        exp_t e;
        int   lat;
        start = 1'b1;
        in1   = a[N-1:0];
        in2   = b[N-1:0];
        @(posedge clk);
        #1;
        ref_model(a, b, e.g, lat);
        e.due = cyc + lat;
        q.push_back(e);
        start = 1'b0;
    endtask

    // Wait for all outstanding work to drain, scrambling operands meanwhile.
    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            in1 = N'($urandom);
            in2 = N'($urandom);
            n   = n + 1;
        end
        if (q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain_timeout: got=%0d pending want=0", q.size());
        end
    endtask

    // Wait until done is visible (posedge+1) so the next start lands in
    // the done cycle.
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        if (done !== 1'b1) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL done_timeout: got=%0d want=1", done);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            exp_hold  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) check("done_width", 2, 1);
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("hcf", int'(hcf), e.g);
                    check("latency_cycle", cyc, e.due);
                    exp_hold = e.g;
                end
            end else begin
                check("hold", int'(hcf), exp_hold);
                if (q.size() != 0 && cyc > q[0].due) begin
                    check("missing_done", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
            check("busy", int'(busy), (q.size() != 0) ? 1 : 0);
            prev_done = done;
        end
    end

    initial begin : driver
        int a, b, held;
        total     = 0;
        bad       = 0;
        exp_hold  = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        in1       = '0;
        in2       = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_hcf", int'(hcf), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // Directed pairs, including latency and boundary operands
        start_op(27, 45);   wait_idle();
        start_op(56, 84);   wait_idle();
        start_op(49, 77);   wait_idle();
        start_op(17, 103);  wait_idle();
        start_op(100, 70);  wait_idle();
        start_op(255, 1);   wait_idle();
        start_op(1, 255);   wait_idle();
        start_op(0, 36);    wait_idle();
        start_op(36, 0);    wait_idle();
        start_op(0, 0);     wait_idle();
        start_op(200, 200); wait_idle();
        start_op(255, 255); wait_idle();

        // start while busy is ignored
        start_op(56, 84);
        start = 1'b1;
        in1   = 8'd17;
        in2   = 8'd103;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // start in the done cycle is accepted
        start_op(56, 84);
        wait_done();
        start_op(17, 103);
        wait_idle();

        // Hold check: result stays put while idle with moving operands
        start_op(108, 24);
        wait_idle();
        repeat (20) begin
            @(posedge clk);
            #1;
            in1 = N'($urandom);
            in2 = N'($urandom);
        end
        check("hold_after_idle", int'(hcf), 12);

        // Reset mid-operation
        start_op(255, 1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_hcf", int'(hcf), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        start_op(100, 70);
        wait_idle();

        // Randomized operations, some launched back-to-back in the done cycle
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       begin a = 0; b = $urandom_range(0, 255); end
                1:       begin a = $urandom_range(0, 255); b = 0; end
                2:       begin a = $urandom_range(0, 255); b = a; end
                default: begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
            endcase
            start_op(a, b);
            if ($urandom_range(0, 2) == 0) begin
                wait_done();
            end else begin
                wait_idle();
                held = $urandom_range(0, 3);
                repeat (held) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/highest_common_factor.md
Name: highest_common_factor

Overview:
- Iterative greatest-common-divisor (highest common factor) engine for two unsigned N-bit operands.
- Uses the subtractive Euclid algorithm, one subtract per clock, under a start/done handshake.
- Sits as a small arithmetic coprocessor: a controller loads two operands, pulses start, and reads hcf when done pulses.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- in1  input  N  first unsigned operand, sampled on the accepted start edge.
- in2  input  N  second unsigned operand, sampled on the accepted start edge.
- busy  output  1  high while a computation is in progress (CALC state).
- done  output  1  one-cycle pulse when hcf is updated with a new result.
- hcf  output  N  last computed highest common factor; held between computations.

Behaviour:
- Reset (rst=1 at a rising edge) returns the state to IDLE and clears busy, done, hcf and the internal registers a and b to 0.
  - Reset takes priority over everything, including mid-computation; the partial result is discarded.
- States are IDLE and CALC.
- IDLE:
  - done is 0 unless the previous cycle finished a computation.
  - If start=1: a<=in1, b<=in2, go to CALC, busy<=1.
  - Otherwise remain in IDLE.
- CALC, evaluated in priority order each cycle:
  1. a==0: hcf<=b, finish.
  2. b==0: hcf<=a, finish.
  3. a==b: hcf<=a, finish.
  4. a>b: a<=a-b, stay in CALC.
  5. else: b<=b-a, stay in CALC.
- Finish means: done<=1 for exactly one cycle, busy<=0, return to IDLE.
- start while busy=1 is ignored. Operand changes while busy do not affect the result.
- start asserted in the same cycle that done is high is accepted, because the state is already IDLE. Back-to-back computations are therefore legal, with no dead cycle required after done.
- Latency: with start accepted at edge E0 and k subtractions needed, done and the new hcf appear after edge E0+k+1.
  - Example: 27,45 needs k=3 (45->18, 27->9, 18->9), so done rises after E0+4.
  - Worst case for N=8 is (255,1) or (1,255): k=254, latency 255 cycles.
- Zero operands:
  - hcf(0,x)=x and hcf(x,0)=x.
  - hcf(0,0)=0, with latency 1 cycle after acceptance.
- Equal operands: hcf(x,x)=x, latency 1.
- Arithmetic: unsigned, and subtraction never underflows because only the larger operand is reduced. The result fits in N bits; no overflow is possible.
- hcf changes only on a finish cycle or on reset. It is stable and valid from the cycle done is high until the next finish.

Test Plan:
- Reset then directed pairs, each started from IDLE and checked on the done pulse:
  - (27,45)->9
  - (56,84)->28
  - (49,77)->7
  - (108,24)->12
  - (17,103)->1
  - (100,70)->10
  - Check done is exactly one cycle wide and busy is high throughout CALC.
- Latency check: (27,45) -> done exactly 4 cycles after the start edge. (255,1) -> hcf=1 with done 255 cycles after start.
- Boundary operands:
  - (0,36)->36 and (36,0)->36.
  - (0,0)->0 with latency 1.
  - (200,200)->200 with latency 1.
  - (255,255)->255.
- Handshake robustness:
  - Start (56,84), then pulse start with (17,103) while busy -> result is 28, not 1.
  - Start (17,103) in the done cycle -> accepted; the next done gives 1.
- Reset mid-operation: start (255,1), assert rst at cycle 10 -> hcf=0, busy=0, done=0 next cycle. Then start (100,70) -> 10.
- Hold check: after (108,24)->12, idle for 20 cycles with changing in1/in2 and start=0 -> hcf stays 12 and done stays 0.
